stage_memory: RTL and testbench

STAGE_MEMORY -- requirements
Module: stage_memory

---
 rtl/stage_memory.sv | 144 ++++++++++++++
 tb/tb_stage_memory.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_memory.sv
// Memory stage of a simple in-order pipeline: ALU pass-through, word-aligned
// load/store over a request/ack bus, bypass network and writeback register.
module stage_memory (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    output logic        stall,
    input  logic [3:0]  in_addr,
    input  logic [31:0] in_val,
    input  logic        is_mem,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_val,
    input  logic        mem_write,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        fwd_valid,
    output logic [3:0]  fwd_addr,
    output logic [31:0] fwd_val,
    output logic [3:0]  out_addr,
    output logic [31:0] out_val,
    output logic        misalign
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_bus_req;
    logic        r_we;
    logic [29:0] r_word;
    logic [31:0] r_wdata;
    logic [3:0]  r_dst;
    logic [31:0] r_rdata;
    logic [3:0]  r_out_addr;
    logic [31:0] r_out_val;
    logic        r_misalign;

    logic        w_aligned;
    logic        w_accept;
    logic        w_misal;
    logic [3:0]  w_res_addr;
    logic [31:0] w_res_val;

    assign w_aligned = (mem_addr[1:0] == 2'b00);
    assign w_accept  = (r_state == IDLE) && is_mem && w_aligned && !stall_in;
    assign w_misal   = (r_state == IDLE) && is_mem && !w_aligned && !stall_in;

    // The execute stage holds its instruction until the access reaches DONE.
    assign stall = stall_in | (is_mem & w_aligned & (r_state != DONE));

    assign bus_req   = r_bus_req;
    assign bus_we    = r_we;
    assign bus_addr  = {r_word, 2'b00};
    assign bus_wdata = r_wdata;
    assign out_addr  = r_out_addr;
    assign out_val   = r_out_val;
    assign misalign  = r_misalign;

    always_comb begin
        w_res_addr = '0;
        w_res_val  = '0;
        if (r_state == DONE) begin
            if (!r_we) begin
                w_res_addr = r_dst;
                w_res_val  = r_rdata;
            end
        end else if (!is_mem) begin
            w_res_addr = in_addr;
            w_res_val  = in_val;
        end
    end

    always_comb begin
        fwd_valid = 1'b0;
        fwd_addr  = '0;
        fwd_val   = '0;
        if (r_state == DONE) begin
            if (!r_we) begin
                fwd_valid = 1'b1;
                fwd_addr  = r_dst;
                fwd_val   = r_rdata;
            end
        end else if (!is_mem) begin
            fwd_valid = 1'b1;
            fwd_addr  = in_addr;
            fwd_val   = in_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_bus_req  <= 1'b0;
            r_out_addr <= '0;
            r_out_val  <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misal;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_word    <= mem_addr[31:2];
                        r_wdata   <= mem_val;
                        r_we      <= mem_write;
                        r_dst     <= in_addr;
                        r_bus_req <= 1'b1;
                        r_state   <= BUSY;
                    end
                end
                BUSY: begin
                    // Ack is taken even under downstream stall; DONE then waits.
                    if (bus_ack) begin
                        r_rdata   <= bus_rdata;
                        r_bus_req <= 1'b0;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (!stall_in) r_state <= IDLE;
                end
                default: begin
                    r_bus_req <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase

            if (!stall) begin
                r_out_addr <= w_res_addr;
                r_out_val  <= w_res_val;
            end else if (!stall_in) begin
                r_out_addr <= '0;
                r_out_val  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_stage_memory.sv
// Randomized scoreboard bench for stage_memory: a transaction-level model
// predicts per-cycle handshakes and the retired writeback of each instruction.
module tb_stage_memory;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_in = 1'b0;
    logic        stall;
    logic [3:0]  in_addr = '0;
    logic [31:0] in_val = '0;
    logic        is_mem = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_val = '0;
    logic        mem_write = 1'b0;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        fwd_valid;
    logic [3:0]  fwd_addr;
    logic [31:0] fwd_val;
    logic [3:0]  out_addr;
    logic [31:0] out_val;
    logic        misalign;

    stage_memory dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .stall(stall),
        .in_addr(in_addr), .in_val(in_val), .is_mem(is_mem),
        .mem_addr(mem_addr), .mem_val(mem_val), .mem_write(mem_write),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_val(fwd_val),
        .out_addr(out_addr), .out_val(out_val), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        sin;
        logic        stall;
        logic        retire;
        logic        mis;
        logic        breq;
        logic        bwe;
        logic        fv;
        logic [3:0]  fa;
        logic [31:0] fd;
        logic [31:0] baddr;
        logic [31:0] bwd;
    } cyc_t;

    cyc_t        cyc_q[$];
    logic [35:0] sb_q[$];
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic rst_cycle();
        cyc_t        c;
        logic [31:0] v;
        @(posedge clk); #2;
        v = $urandom();
        rst = 1'b1; stall_in = 1'b0; is_mem = 1'b0; mem_write = 1'b0;
        in_addr = v[3:0]; in_val = v; mem_addr = '0; mem_val = '0;
        bus_ack = v[4]; bus_rdata = $urandom();
        c = '0;
        c.rst = 1'b1; c.fv = 1'b1; c.fa = v[3:0]; c.fd = v;
        cyc_q.push_back(c);
    endtask

    // One instruction from issue to retirement; sp/sa are percent chances of
    // downstream stall and of a stray ack outside the bus transfer.
    task automatic issue(input logic m, input logic w, input logic [3:0] dst,
                         input logic [31:0] v, input logic [31:0] ma,
                         input logic [31:0] mv, input int dly,
                         input logic [31:0] rd, input int unsigned sp,
                         input int hold, input int abort_at, input int unsigned sa);
        logic mis, mem, s, ack, st, done;
        int   ph, cnt, n, hcnt;
        cyc_t c;
        mis = m && (ma[1:0] != 2'b00);
        mem = m && !mis;
        ph = 0; cnt = 0; n = 0; hcnt = 0; done = 1'b0;
        if (!m) sb_q.push_back({dst, v});
        else if (mis || w) sb_q.push_back('0);
        else sb_q.push_back({dst, rd});
        while (!done) begin
            if (mem && ph == 1 && cnt == abort_at) begin
                sb_q.delete(sb_q.size() - 1);
                rst_cycle();
                done = 1'b1;
            end else begin
                @(posedge clk); #2;
                s = (n < 8) && ($urandom_range(99) < sp);
                if (hcnt > 0) begin
                    s = 1'b1;
                    hcnt--;
                end
                ack = 1'b0;
                if (mem && ph == 1) begin
                    if (cnt == dly) begin
                        ack = 1'b1;
                        if (hold > 0) begin
                            s = 1'b1;
                            hcnt = hold - 1;
                        end
                    end
                end else begin
                    ack = ($urandom_range(99) < sa);
                end
                rst = 1'b0; stall_in = s; in_addr = dst; in_val = v; is_mem = m;
                mem_addr = ma; mem_val = mv; mem_write = w; bus_ack = ack;
                bus_rdata = (mem && ph == 1 && ack) ? rd : $urandom();
                st = (mem && ph != 2) ? 1'b1 : s;
                c = '0;
                c.sin = s; c.stall = st; c.retire = !st; c.mis = mis && !s;
                c.breq = mem && (ph == 1); c.bwe = w;
                c.baddr = {ma[31:2], 2'b00}; c.bwd = mv;
                if (!m) begin
                    c.fv = 1'b1; c.fa = dst; c.fd = v;
                end else if (mem && !w && ph == 2) begin
                    c.fv = 1'b1; c.fa = dst; c.fd = rd;
                end
                cyc_q.push_back(c);
                if (!st) done = 1'b1;
                else if (mem) begin
                    if (ph == 0 && !s) ph = 1;
                    else if (ph == 1) begin
                        if (ack) ph = 2;
                        else cnt++;
                    end
                end
                n++;
            end
        end
    endtask

    initial begin : monitor
        cyc_t        c;
        logic [3:0]  ea;
        logic [31:0] ev;
        logic [35:0] r;
        ea = '0;
        ev = '0;
        forever begin
            @(negedge clk);
            if (cyc_q.size() != 0) begin
                c = cyc_q.pop_front();
                chk("fwd_valid", fwd_valid, c.fv);
                if (c.fv) begin
                    chk("fwd_addr", fwd_addr, c.fa);
                    chk("fwd_val", fwd_val, c.fd);
                end
                if (!c.rst) begin
                    chk("stall", stall, c.stall);
                    chk("bus_req", bus_req, c.breq);
                    if (c.breq) begin
                        chk("bus_we", bus_we, c.bwe);
                        chk("bus_addr", bus_addr, c.baddr);
                        chk("bus_wdata", bus_wdata, c.bwd);
                    end
                end
                @(posedge clk); #1;
                if (c.rst) begin
                    ea = '0;
                    ev = '0;
                    chk("misalign_rst", misalign, 1'b0);
                    chk("bus_req_rst", bus_req, 1'b0);
                end else begin
                    if (c.retire) begin
                        if (sb_q.size() == 0) begin
                            chk("sb_underflow", 32'd0, 32'd1);
                        end else begin
                            r = sb_q.pop_front();
                            ea = r[35:32];
                            ev = r[31:0];
                        end
                    end else if (!c.sin) begin
                        ea = '0;
                        ev = '0;
                    end
                    chk("misalign", misalign, c.mis);
                end
                chk("out_addr", out_addr, ea);
                chk("out_val", out_val, ev);
            end
        end
    end

    initial begin : driver
        repeat (3) rst_cycle();
        issue(1'b0, 1'b0, 4'd3, 32'h1234, '0, '0, 0, '0, 0, 0, -1, 0);
        issue(1'b1, 1'b0, 4'd5, '0, 32'h100, '0, 0, 32'hDEADBEEF, 0, 0, -1, 0);
        issue(1'b1, 1'b1, 4'd7, '0, 32'h204, 32'hCAFEF00D, 3, '0, 0, 0, -1, 0);
        issue(1'b1, 1'b0, 4'd4, '0, 32'h102, '0, 0, '0, 0, 0, -1, 0);
        issue(1'b1, 1'b0, 4'd6, '0, 32'h300, '0, 10, 32'h55AA, 0, 0, 2, 0);
        issue(1'b0, 1'b0, 4'd0, '0, '0, '0, 0, '0, 0, 0, -1, 100);
        issue(1'b1, 1'b0, 4'd9, '0, 32'h40, '0, 1, 32'h13572468, 0, 3, -1, 0);
        for (int i = 0; i < 300; i++) begin
            int unsigned k;
            int unsigned ml;
            int          dl;
            int          hd;
            logic [31:0] a;
            logic [31:0] b;
            logic [31:0] r;
            logic [3:0]  d;
            k = $urandom_range(99);
            a = $urandom();
            b = $urandom();
            r = $urandom();
            d = 4'($urandom_range(15));
            ml = $urandom_range(1, 3);
            dl = int'($urandom_range(3));
            hd = ($urandom_range(3) == 0) ? int'($urandom_range(1, 3)) : 0;
            if ($urandom_range(99) < 2) rst_cycle();
            if (k < 40)
                issue(1'b0, 1'b0, d, b, a, r, 0, r, 25, 0, -1, 15);
            else if (k < 85)
                issue(1'b1, k[0], d, b, {a[31:2], 2'b00}, r, dl, b ^ r, 25, hd, -1, 15);
            else
                issue(1'b1, k[0], d, b, {a[31:2], 2'(ml)}, r, 0, r, 25, 0, -1, 15);
        end
        repeat (2) @(posedge clk);
        #3;
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
